// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with a built-in ID/EX pipeline register.
// Holds the register file, decodes ARM-style instructions, evaluates the
// condition field, stalls on RAW hazards against EX/MEM destinations and
// hands decoded bundles to EX under a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready      IF -> ID handshake
//   pc_in, instr_in          PC+4 and instruction word from IF
//   status_reg               {N,Z,C,V} flags for condition evaluation
//   wb_en/wb_addr/wb_data    register file write port
//   ex_dst/ex_wb_en          destination of the instruction in EX
//   mem_dst/mem_wb_en        destination of the instruction in MEM
//   flush                    branch taken: discard ID contents
//   ex_ready / out_valid     ID -> EX handshake
//   out_pc..out_ctrl         registered decoded bundle
//   stall_cnt                saturating count of hazard-stall cycles
module id_stage_pipe #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 16,
    parameter int unsigned REG_AW     = 4,
    parameter bit          WB_BYPASS  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] pc_in,
    input  logic [31:0]           instr_in,
    input  logic [3:0]            status_reg,
    input  logic                  wb_en,
    input  logic [REG_AW-1:0]     wb_addr,
    input  logic [WORD_WIDTH-1:0] wb_data,
    input  logic [REG_AW-1:0]     ex_dst,
    input  logic                  ex_wb_en,
    input  logic [REG_AW-1:0]     mem_dst,
    input  logic                  mem_wb_en,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_pc,
    output logic [WORD_WIDTH-1:0] out_rn,
    output logic [WORD_WIDTH-1:0] out_rm,
    output logic [REG_AW-1:0]     out_dst,
    output logic [11:0]           out_shop,
    output logic [23:0]           out_simm,
    output logic                  out_imm,
    output logic [8:0]            out_ctrl,
    output logic [15:0]           stall_cnt
);

    logic [WORD_WIDTH-1:0] r_regs [REG_COUNT];

    logic                  r_out_valid;
    logic [WORD_WIDTH-1:0] r_out_pc, r_out_rn, r_out_rm;
    logic [REG_AW-1:0]     r_out_dst;
    logic [11:0]           r_out_shop;
    logic [23:0]           r_out_simm;
    logic                  r_out_imm;
    logic [8:0]            r_out_ctrl;
    logic [15:0]           r_stall_cnt;

    logic [1:0]            w_mode;
    logic [3:0]            w_op;
    logic                  w_is_store, w_is_branch, w_is_movmvn;
    logic [REG_AW-1:0]     w_src1, w_src2;
    logic [WORD_WIDTH-1:0] w_rn, w_rm;
    logic                  w_s, w_b, w_mem_wr, w_mem_rd, w_wb;
    logic [3:0]            w_excmd;
    logic                  w_n, w_z, w_c, w_v, w_cond_ok;
    logic [8:0]            w_ctrl;
    logic                  w_has_src1, w_has_src2, w_hit1, w_hit2;
    logic                  w_hazard, w_load;

    assign w_mode      = instr_in[27:26];
    assign w_op        = instr_in[24:21];
    assign w_is_store  = (w_mode == 2'b01) && !instr_in[20];
    assign w_is_branch = (w_mode == 2'b10);
    assign w_is_movmvn = (w_mode == 2'b00) && ((w_op == 4'b1101) || (w_op == 4'b1111));

    // A store reads its data register (Rd) through the second read port.
    assign w_src1 = instr_in[16 +: REG_AW];
    assign w_src2 = w_is_store ? instr_in[12 +: REG_AW] : instr_in[0 +: REG_AW];

    assign w_rn = (WB_BYPASS && wb_en && (wb_addr == w_src1)) ? wb_data : r_regs[w_src1];
    assign w_rm = (WB_BYPASS && wb_en && (wb_addr == w_src2)) ? wb_data : r_regs[w_src2];

    always_comb begin
        w_s      = 1'b0;
        w_b      = 1'b0;
        w_excmd  = 4'b0000;
        w_mem_wr = 1'b0;
        w_mem_rd = 1'b0;
        w_wb     = 1'b0;
        case (w_mode)
            2'b00: begin
                w_s  = instr_in[20];
                w_wb = 1'b1;
                case (w_op)
                    4'b1101: w_excmd = 4'b0001;  // MOV
                    4'b1111: w_excmd = 4'b1001;  // MVN
                    4'b0100: w_excmd = 4'b0010;  // ADD
                    4'b0101: w_excmd = 4'b0011;  // ADC
                    4'b0010: w_excmd = 4'b0100;  // SUB
                    4'b0110: w_excmd = 4'b0101;  // SBC
                    4'b0000: w_excmd = 4'b0110;  // AND
                    4'b1100: w_excmd = 4'b0111;  // ORR
                    4'b0001: w_excmd = 4'b1000;  // EOR
                    4'b1010: begin               // CMP
                        w_excmd = 4'b0100;
                        w_wb    = 1'b0;
                    end
                    4'b1000: begin               // TST
                        w_excmd = 4'b0110;
                        w_wb    = 1'b0;
                    end
                    default: begin
                        w_s  = 1'b0;
                        w_wb = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                w_excmd = 4'b0010;
                if (instr_in[20]) begin
                    w_mem_rd = 1'b1;
                    w_wb     = 1'b1;
                end else begin
                    w_mem_wr = 1'b1;
                end
            end
            2'b10:   w_b = 1'b1;
            default: ;
        endcase
    end

    assign {w_n, w_z, w_c, w_v} = status_reg;

    always_comb begin
        w_cond_ok = 1'b0;
        case (instr_in[31:28])
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = !w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = !w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = !w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = !w_v;
            4'b1000: w_cond_ok = w_c && !w_z;
            4'b1001: w_cond_ok = !w_c || w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = !w_z && (w_n == w_v);
            4'b1101: w_cond_ok = w_z || (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    // A failed condition turns the instruction into a NOP but keeps it valid.
    assign w_ctrl = w_cond_ok ? {w_s, w_b, w_excmd, w_mem_wr, w_mem_rd, w_wb} : 9'd0;

    assign w_has_src1 = !w_is_movmvn && !w_is_branch;
    assign w_has_src2 = !instr_in[25] || w_is_store;
    assign w_hit1     = (ex_wb_en && (ex_dst == w_src1)) || (mem_wb_en && (mem_dst == w_src1));
    assign w_hit2     = (ex_wb_en && (ex_dst == w_src2)) || (mem_wb_en && (mem_dst == w_src2));
    assign w_hazard   = in_valid && ((w_has_src1 && w_hit1) || (w_has_src2 && w_hit2));
    assign w_load     = !r_out_valid || ex_ready;
    assign in_ready   = w_load && !w_hazard && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_rn    <= '0;
            r_out_rm    <= '0;
            r_out_dst   <= '0;
            r_out_shop  <= '0;
            r_out_simm  <= '0;
            r_out_imm   <= 1'b0;
            r_out_ctrl  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
        end else if (w_load) begin
            if (in_valid && !w_hazard) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= pc_in;
                r_out_rn    <= w_rn;
                r_out_rm    <= w_rm;
                r_out_dst   <= instr_in[12 +: REG_AW];
                r_out_shop  <= instr_in[11:0];
                r_out_simm  <= instr_in[23:0];
                r_out_imm   <= instr_in[25];
                r_out_ctrl  <= w_ctrl;
            end else begin
                // Bubble: nothing to hand over, or a source is not yet written back.
                r_out_valid <= 1'b0;
                r_out_ctrl  <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && w_load && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_rn    = r_out_rn;
    assign out_rm    = r_out_rm;
    assign out_dst   = r_out_dst;
    assign out_shop  = r_out_shop;
    assign out_simm  = r_out_simm;
    assign out_imm   = r_out_imm;
    assign out_ctrl  = r_out_ctrl;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed vector bench for id_stage_pipe.
// A table of single-instruction decode vectors plus hand-written sequences
// for bypass, hazard stalls, back-pressure, flush and asynchronous reset.
module tb_id_stage_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic [3:0]  status_reg;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  ex_dst;
    logic        ex_wb_en;
    logic [3:0]  mem_dst;
    logic        mem_wb_en;
    logic        flush;
    logic        ex_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_rn;
    logic [31:0] out_rm;
    logic [3:0]  out_dst;
    logic [11:0] out_shop;
    logic [23:0] out_simm;
    logic        out_imm;
    logic [8:0]  out_ctrl;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    id_stage_pipe #(
        .WORD_WIDTH(32),
        .REG_COUNT (16),
        .REG_AW    (4),
        .WB_BYPASS (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .status_reg(status_reg),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ex_dst    (ex_dst),
        .ex_wb_en  (ex_wb_en),
        .mem_dst   (mem_dst),
        .mem_wb_en (mem_wb_en),
        .flush     (flush),
        .ex_ready  (ex_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_rn    (out_rn),
        .out_rm    (out_rm),
        .out_dst   (out_dst),
        .out_shop  (out_shop),
        .out_simm  (out_simm),
        .out_imm   (out_imm),
        .out_ctrl  (out_ctrl),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  st;
        logic [8:0]  ctrl;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  dst;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    localparam logic [31:0] ADD_R1_R2_R3 = 32'hE0821003;
    localparam logic [31:0] STR_R4_R1    = 32'hE5814000;
    localparam logic [8:0]  CTRL_ADD     = 9'b0_0_0010_001;
    localparam logic [8:0]  CTRL_STR     = 9'b0_0_0010_100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
        in_valid = 1'b0;
        wb_en    = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_en    = 1'b0;
    endtask

    initial begin
        // {instr, NZCV, ctrl, rn, rm, dst}; R1=100 R2=5 R3=7 R4=0x44, others 0
        vecs[0]  = '{32'hE0821003, 4'b0000, 9'b0_0_0010_001, 32'd5,   32'd7,    4'd1}; // ADD
        vecs[1]  = '{32'hE0525003, 4'b0000, 9'b1_0_0100_001, 32'd5,   32'd7,    4'd5}; // SUBS
        vecs[2]  = '{32'hE3A060FF, 4'b0000, 9'b0_0_0001_001, 32'd0,   32'd0,    4'd6}; // MOV imm
        vecs[3]  = '{32'hE1520003, 4'b0000, 9'b1_0_0100_000, 32'd5,   32'd7,    4'd0}; // CMP
        vecs[4]  = '{32'hE5917000, 4'b0000, 9'b0_0_0010_011, 32'd100, 32'd0,    4'd7}; // LDR
        vecs[5]  = '{32'hE5814000, 4'b0000, 9'b0_0_0010_100, 32'd100, 32'h44,  4'd4}; // STR
        vecs[6]  = '{32'hEA000010, 4'b0000, 9'b0_1_0000_000, 32'd0,   32'd0,    4'd0}; // B
        vecs[7]  = '{32'h00821003, 4'b0000, 9'b0_0_0000_000, 32'd5,   32'd7,    4'd1}; // ADDEQ Z=0
        vecs[8]  = '{32'h00821003, 4'b0100, 9'b0_0_0010_001, 32'd5,   32'd7,    4'd1}; // ADDEQ Z=1
        vecs[9]  = '{32'hC0821003, 4'b1000, 9'b0_0_0000_000, 32'd5,   32'd7,    4'd1}; // ADDGT N!=V
        vecs[10] = '{32'hA0821003, 4'b1001, 9'b0_0_0010_001, 32'd5,   32'd7,    4'd1}; // ADDGE N=V
        vecs[11] = '{32'h80821003, 4'b0010, 9'b0_0_0010_001, 32'd5,   32'd7,    4'd1}; // ADDHI
        vecs[12] = '{32'hF0821003, 4'b0100, 9'b0_0_0000_000, 32'd5,   32'd7,    4'd1}; // never
        vecs[13] = '{32'hEC821003, 4'b0000, 9'b0_0_0000_000, 32'd5,   32'd7,    4'd1}; // mode 11
        vecs[14] = '{32'hE1E08003, 4'b0000, 9'b0_0_1001_001, 32'd0,   32'd7,    4'd8}; // MVN
        vecs[15] = '{32'hE0321003, 4'b0000, 9'b1_0_1000_001, 32'd5,   32'd7,    4'd1}; // EORS
        vecs[16] = '{32'hE0621003, 4'b0000, 9'b0_0_0000_000, 32'd5,   32'd7,    4'd1}; // unknown op
        vecs[17] = '{32'hE1821003, 4'b0000, 9'b0_0_0111_001, 32'd5,   32'd7,    4'd1}; // ORR

        rst        = 1'b1;
        in_valid   = 1'b0;
        pc_in      = '0;
        instr_in   = '0;
        status_reg = '0;
        wb_en      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        ex_dst     = '0;
        ex_wb_en   = 1'b0;
        mem_dst    = '0;
        mem_wb_en  = 1'b0;
        flush      = 1'b0;
        ex_ready   = 1'b1;
        tick();
        tick();

        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_ctrl", 32'(out_ctrl), 32'd0);
        check("reset out_pc", out_pc, 32'd0);
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;

        write_reg(4'd1, 32'd100);
        write_reg(4'd2, 32'd5);
        write_reg(4'd3, 32'd7);
        write_reg(4'd4, 32'h44);
        check("bubble when idle", 32'(out_valid), 32'd0);

        // Decode table
        for (int i = 0; i < NVEC; i++) begin
            in_valid   = 1'b1;
            instr_in   = vecs[i].instr;
            status_reg = vecs[i].st;
            pc_in      = 32'h1000 + 32'(i * 4);
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d out_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d out_rn", i), out_rn, vecs[i].rn);
            check($sformatf("vec%0d out_rm", i), out_rm, vecs[i].rm);
            check($sformatf("vec%0d out_dst", i), 32'(out_dst), 32'(vecs[i].dst));
            check($sformatf("vec%0d out_pc", i), out_pc, 32'h1000 + 32'(i * 4));
            check($sformatf("vec%0d out_shop", i), 32'(out_shop), 32'(vecs[i].instr[11:0]));
        end
        status_reg = 4'b0000;

        // Same-cycle write bypass, then the write is visible from the regfile
        instr_in = ADD_R1_R2_R3;
        wb_en    = 1'b1;
        wb_addr  = 4'd2;
        wb_data  = 32'd9;
        tick();
        wb_en = 1'b0;
        check("bypass out_rn", out_rn, 32'd9);
        check("bypass out_rm", out_rm, 32'd7);
        tick();
        check("regfile after write", out_rn, 32'd9);
        write_reg(4'd2, 32'd5);

        // EX hazard on src1
        in_valid = 1'b1;
        instr_in = ADD_R1_R2_R3;
        ex_dst   = 4'd2;
        ex_wb_en = 1'b1;
        #1;
        check("ex hazard in_ready", 32'(in_ready), 32'd0);
        tick();
        check("ex hazard out_valid", 32'(out_valid), 32'd0);
        check("ex hazard out_ctrl", 32'(out_ctrl), 32'd0);
        check("ex hazard stall_cnt", 32'(stall_cnt), 32'd1);

        // MEM hazard on src2
        ex_wb_en  = 1'b0;
        mem_dst   = 4'd3;
        mem_wb_en = 1'b1;
        #1;
        check("mem hazard in_ready", 32'(in_ready), 32'd0);
        tick();
        check("mem hazard stall_cnt", 32'(stall_cnt), 32'd2);

        // Immediate form has no src2, so R3 in MEM does not stall it
        instr_in = 32'hE2821003;
        #1;
        check("imm no hazard in_ready", 32'(in_ready), 32'd1);
        tick();
        check("imm accepted", 32'(out_valid), 32'd1);
        check("imm ctrl", 32'(out_ctrl), 32'(CTRL_ADD));
        check("imm out_imm", 32'(out_imm), 32'd1);
        check("imm stall_cnt", 32'(stall_cnt), 32'd2);

        // Store reads Rd, so Rd in EX stalls it
        mem_wb_en = 1'b0;
        instr_in  = STR_R4_R1;
        ex_dst    = 4'd4;
        ex_wb_en  = 1'b1;
        #1;
        check("store hazard in_ready", 32'(in_ready), 32'd0);
        tick();
        check("store hazard stall_cnt", 32'(stall_cnt), 32'd3);
        ex_wb_en = 1'b0;
        pc_in    = 32'h2000;
        tick();
        check("store accepted", 32'(out_valid), 32'd1);
        check("store ctrl", 32'(out_ctrl), 32'(CTRL_STR));
        check("store out_rm", out_rm, 32'h44);

        // Back-pressure: output held for 3 cycles; hazard while held is not counted
        ex_ready = 1'b0;
        instr_in = ADD_R1_R2_R3;
        pc_in    = 32'h3000;
        ex_dst   = 4'd2;
        ex_wb_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
            tick();
            check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d out_ctrl", k), 32'(out_ctrl), 32'(CTRL_STR));
            check($sformatf("hold%0d out_pc", k), out_pc, 32'h2000);
        end
        check("hold stall_cnt", 32'(stall_cnt), 32'd3);

        // Flush while held; regfile write still lands
        ex_wb_en = 1'b0;
        flush    = 1'b1;
        wb_en    = 1'b1;
        wb_addr  = 4'd5;
        wb_data  = 32'h55;
        #1;
        check("flush in_ready", 32'(in_ready), 32'd0);
        tick();
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush out_ctrl", 32'(out_ctrl), 32'd0);
        flush    = 1'b0;
        wb_en    = 1'b0;
        ex_ready = 1'b1;
        instr_in = 32'hE0851003;
        tick();
        check("write during flush", out_rn, 32'h55);
        check("after flush valid", 32'(out_valid), 32'd1);

        // Flush with a valid instruction and EX ready
        instr_in = ADD_R1_R2_R3;
        flush    = 1'b1;
        tick();
        check("flush2 out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        tick();
        check("accept after flush2", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        tick();
        check("idle bubble valid", 32'(out_valid), 32'd0);
        check("idle bubble ctrl", 32'(out_ctrl), 32'd0);

        // Asynchronous reset mid-stream
        in_valid = 1'b1;
        tick();
        check("pre-reset valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst out_valid", 32'(out_valid), 32'd0);
        check("async rst out_ctrl", 32'(out_ctrl), 32'd0);
        check("async rst out_rn", out_rn, 32'd0);
        check("async rst out_pc", out_pc, 32'd0);
        check("async rst stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("regfile cleared rn", out_rn, 32'd0);
        check("regfile cleared rm", out_rm, 32'd0);
        check("post-reset valid", 32'(out_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
